flip_sequencer: RTL and testbench

//  Initiator-side controller for the word adapter's st_read/st_write interface. Walks a rectangle
//  of multi-byte words in byte-wide BRAM in row-major order. Per word: request a read, wait for

---
 rtl/flip_sequencer.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_flip_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flip_sequencer.sv
//------------------------------------------------------------------------------
// flip_sequencer
//
// Purpose:
//   Initiator-side controller for the word adapter's st_read/st_write
//   interface. Walks a rectangle of multi-byte words stored in byte-wide BRAM
//   in row-major order. For every word it requests a read, waits for
//   flip_ready, byte-reverses the returned word, requests a write-back to the
//   same address and waits for wrt_done. The adapter is the only BRAM master;
//   this block only issues one-cycle requests and waits for the acks.
//
// Parameters:
//   DATA_WIDTH      bits per BRAM byte lane
//   WORD_BYTES      bytes per word (also the column address step)
//   TIMEOUT_CYCLES  cycles to wait for an ack before aborting the pass (>= 2)
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   start        in   begin a rectangle pass (only looked at while idle)
//   rect_base    in   byte address of word (row 0, col 0)
//   rect_cols    in   words per row (0 = empty rectangle)
//   rect_rows    in   rows (0 = empty rectangle)
//   row_pitch    in   byte stride between rows
//   st_read      out  one-cycle read request to the adapter
//   st_write     out  one-cycle write request to the adapter
//   base_addr    out  word byte address, held through the ack
//   write_data   out  byte-reversed word, held through wrt_done
//   read_data    in   word from the adapter, valid with flip_ready
//   flip_ready   in   read complete (one-cycle pulse)
//   wrt_done     in   write complete (one-cycle pulse)
//   busy         out  high from start acceptance until done
//   done         out  one-cycle pulse at the end of a pass (normal or abort)
//   err          out  sticky timeout flag, cleared by the next accepted start
//   words_done   out  words fully written back in this pass (saturating)
//
// All outputs are registered. Request strobes, done and busy are produced by
// the datapath register block from the current state, so st_read appears in
// the cycle after RD_REQ, done in the cycle after DONE, and st_write in the
// cycle right after the flip_ready that completed the read.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module flip_sequencer #(
    parameter int DATA_WIDTH     = 8,
    parameter int WORD_BYTES     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [7:0]                       rect_base,
    input  logic [3:0]                       rect_cols,
    input  logic [3:0]                       rect_rows,
    input  logic [7:0]                       row_pitch,
    output logic                             st_read,
    output logic                             st_write,
    output logic [7:0]                       base_addr,
    output logic [WORD_BYTES*DATA_WIDTH-1:0] write_data,
    input  logic [WORD_BYTES*DATA_WIDTH-1:0] read_data,
    input  logic                             flip_ready,
    input  logic                             wrt_done,
    output logic                             busy,
    output logic                             done,
    output logic                             err,
    output logic [7:0]                       words_done
);

    localparam int                WORD_W    = WORD_BYTES * DATA_WIDTH;
    localparam int                TCNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [7:0]        COL_STEP  = 8'(WORD_BYTES);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        ADVANCE,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    // Pass parameters captured at start acceptance.
    logic [3:0] cols_q;
    logic [3:0] rows_q;
    logic [7:0] pitch_q;

    // Walk position. row_base and col_off track the byte address
    // incrementally, so no multiplier is needed; both wrap modulo 256.
    logic [3:0] col;
    logic [3:0] row;
    logic [7:0] row_base;
    logic [7:0] col_off;

    logic [TCNT_W-1:0] tcount;

    // Decoded conditions shared by the FSM and the datapath.
    logic              accept;
    logic              empty_rect;
    logic              rd_ack;
    logic              wr_ack;
    logic              wait_expired;
    logic              col_last;
    logic              last_word;
    logic [WORD_W-1:0] flipped;

    //--------------------------------------------------------------------------
    // Condition decode
    //--------------------------------------------------------------------------
    // NOTE: every signal written in an always_comb gets a default at the top,
    // so no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        accept       = 1'b0;
        empty_rect   = 1'b0;
        rd_ack       = 1'b0;
        wr_ack       = 1'b0;
        wait_expired = 1'b0;
        col_last     = 1'b0;
        last_word    = 1'b0;

        accept     = (state == IDLE) && start;
        empty_rect = (rect_cols == 4'd0) || (rect_rows == 4'd0);

        // Only the ack belonging to the current wait state counts; the other
        // one, and any ack outside a wait state, is ignored.
        rd_ack = (state == RD_WAIT) && flip_ready;
        wr_ack = (state == WR_WAIT) && wrt_done;

        // tcount is 0 in the first waiting cycle, so reaching TCNT_LAST with
        // no ack means TIMEOUT_CYCLES waiting cycles have gone by.
        wait_expired = (((state == RD_WAIT) && !flip_ready) ||
                        ((state == WR_WAIT) && !wrt_done)) &&
                       (tcount == TCNT_LAST);

        col_last  = (col == cols_q - 4'd1);
        last_word = col_last && (row == rows_q - 4'd1);
    end

    // Byte reversal: byte b of the write word is byte (WORD_BYTES-1-b) of
    // the read word.
    always_comb begin
        flipped = '0;
        for (int b = 0; b < WORD_BYTES; b++) begin
            flipped[b*DATA_WIDTH +: DATA_WIDTH] =
                read_data[(WORD_BYTES-1-b)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    //--------------------------------------------------------------------------
    // FSM: state register
    //--------------------------------------------------------------------------
    // NOTE: sequential blocks use non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    //--------------------------------------------------------------------------
    // FSM: next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = empty_rect ? DONE : RD_REQ;
                end
            end
            RD_REQ: begin
                state_next = RD_WAIT;
            end
            RD_WAIT: begin
                if (rd_ack) begin
                    state_next = WR_REQ;
                end else if (wait_expired) begin
                    state_next = DONE;
                end
            end
            WR_REQ: begin
                state_next = WR_WAIT;
            end
            WR_WAIT: begin
                if (wr_ack) begin
                    state_next = ADVANCE;
                end else if (wait_expired) begin
                    state_next = DONE;
                end
            end
            ADVANCE: begin
                state_next = last_word ? DONE : RD_REQ;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Datapath and registered outputs
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_read    <= 1'b0;
            st_write   <= 1'b0;
            base_addr  <= '0;
            write_data <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            words_done <= '0;
            cols_q     <= '0;
            rows_q     <= '0;
            pitch_q    <= '0;
            col        <= '0;
            row        <= '0;
            row_base   <= '0;
            col_off    <= '0;
            tcount     <= '0;
        end else begin
            // Single-cycle strobes: high for exactly one cycle each.
            st_read  <= (state == RD_REQ);
            st_write <= rd_ack;
            done     <= (state == DONE);

            if (accept) begin
                cols_q     <= rect_cols;
                rows_q     <= rect_rows;
                pitch_q    <= row_pitch;
                row_base   <= rect_base;
                col_off    <= '0;
                col        <= '0;
                row        <= '0;
                err        <= 1'b0;
                words_done <= '0;
                busy       <= 1'b1;
            end

            // busy drops in the same cycle that done rises.
            if (state == DONE) begin
                busy <= 1'b0;
            end

            // The address is computed once per word and then held through
            // both the read and the write-back.
            if (state == RD_REQ) begin
                base_addr <= row_base + col_off;
            end

            // The timeout counter restarts on entry to each wait state.
            if ((state == RD_REQ) || (state == WR_REQ)) begin
                tcount <= '0;
            end else if ((state == RD_WAIT) || (state == WR_WAIT)) begin
                tcount <= tcount + TCNT_W'(1);
            end

            // read_data is only valid with flip_ready; reverse it on the way in
            // so write_data is ready alongside st_write.
            if (rd_ack) begin
                write_data <= flipped;
            end

            if (wr_ack && (words_done != 8'hFF)) begin
                words_done <= words_done + 8'd1;
            end

            // An aborted word is not counted; err stays set until next start.
            if (wait_expired) begin
                err <= 1'b1;
            end

            if (state == ADVANCE) begin
                if (col_last) begin
                    col      <= '0;
                    col_off  <= '0;
                    row      <= row + 4'd1;
                    row_base <= row_base + pitch_q;
                end else begin
                    col     <= col + 4'd1;
                    col_off <= col_off + COL_STEP;
                end
            end
        end
    end

endmodule

// File: tb/tb_flip_sequencer.sv
//------------------------------------------------------------------------------
// tb_flip_sequencer
//
// Self-checking bench for flip_sequencer. A behavioural adapter/BRAM model
// answers requests after random latencies; expected addresses, write data and
// word counts come from plain arithmetic on the rectangle description and a
// byte array standing in for the BRAM.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_flip_sequencer;

    localparam int DW = 8;
    localparam int WB = 2;
    localparam int T  = 64;
    localparam int WW = DW * WB;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    rect_base;
    logic [3:0]    rect_cols;
    logic [3:0]    rect_rows;
    logic [7:0]    row_pitch;
    logic          st_read;
    logic          st_write;
    logic [7:0]    base_addr;
    logic [WW-1:0] write_data;
    logic [WW-1:0] read_data;
    logic          flip_ready;
    logic          wrt_done;
    logic          busy;
    logic          done;
    logic          err;
    logic [7:0]    words_done;

    logic [7:0] bram [256];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    flip_sequencer #(
        .DATA_WIDTH    (DW),
        .WORD_BYTES    (WB),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rect_base (rect_base),
        .rect_cols (rect_cols),
        .rect_rows (rect_rows),
        .row_pitch (row_pitch),
        .st_read   (st_read),
        .st_write  (st_write),
        .base_addr (base_addr),
        .write_data(write_data),
        .read_data (read_data),
        .flip_ready(flip_ready),
        .wrt_done  (wrt_done),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .words_done(words_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Address of word idx in row-major order, wrapped to 8 bits.
    function automatic logic [7:0] exp_addr(input logic [7:0] b, input int cols,
                                            input logic [7:0] p, input int idx);
        int v;
        v = int'(b) + (idx / cols) * int'(p) + (idx % cols) * WB;
        return 8'(v % 256);
    endfunction

    // Word as the adapter would return it: byte k comes from address a+k.
    function automatic logic [WW-1:0] bram_word(input logic [7:0] a);
        logic [WW-1:0] w;
        for (int k = 0; k < WB; k++) w[k*DW +: DW] = bram[(int'(a) + k) % 256];
        return w;
    endfunction

    // Expected write-back: byte k is the byte stored at a+(WB-1-k).
    function automatic logic [WW-1:0] flip_word(input logic [7:0] a);
        logic [WW-1:0] w;
        for (int k = 0; k < WB; k++) w[k*DW +: DW] = bram[(int'(a) + WB - 1 - k) % 256];
        return w;
    endfunction

    task automatic check_all_zero(input string pfx);
        check({pfx, "_st_read"},    32'(st_read),    0);
        check({pfx, "_st_write"},   32'(st_write),   0);
        check({pfx, "_busy"},       32'(busy),       0);
        check({pfx, "_done"},       32'(done),       0);
        check({pfx, "_err"},        32'(err),        0);
        check({pfx, "_base_addr"},  32'(base_addr),  0);
        check({pfx, "_write_data"}, 32'(write_data), 0);
        check({pfx, "_words_done"}, 32'(words_done), 0);
    endtask

    // One rectangle pass against the adapter model. mute_rd: never answer a
    // read. pokes: restart attempt while busy plus spurious/overlapping acks.
    task automatic run_pass(input logic [7:0] b, input int c, input int r,
                            input logic [7:0] p, input int max_lat,
                            input bit mute_rd, input bit pokes);
        int exp_words, rd_seen, wr_seen, cyc, rd_cnt, wr_cnt;
        int first_rd, done_cyc, busy_low, busy_high;
        bit rd_fired;
        logic [7:0] rd_addr;

        exp_words = c * r;
        rd_seen = 0; wr_seen = 0; rd_cnt = -1; wr_cnt = -1;
        first_rd = -1; done_cyc = -1; busy_low = 0; busy_high = 0;
        rd_fired = 1'b0; rd_addr = 8'h00;

        rect_base = b; rect_cols = 4'(c); rect_rows = 4'(r); row_pitch = p;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;

        while (done_cyc < 0 && cyc < 3000) begin
            if (cyc == 1) begin
                check("err_clr", 32'(err), 0);
                check("wd_clr", 32'(words_done), 0);
            end
            if (busy) busy_high++;
            else if (!done) busy_low++;

            if (st_read) begin
                check("rd_addr", 32'(base_addr), 32'(exp_addr(b, c, p, rd_seen)));
                if (rd_seen == 0) begin
                    check("rd_lat", cyc, 2);
                    first_rd = cyc;
                end
                rd_addr = base_addr;
                rd_seen++;
                if (!mute_rd) rd_cnt = int'($urandom_range(max_lat, 1));
            end
            if (rd_fired) check("wr_lat", 32'(st_write), 1);
            if (st_write) begin
                check("wr_addr", 32'(base_addr), 32'(rd_addr));
                check("wr_data", 32'(write_data), 32'(flip_word(base_addr)));
                for (int k = 0; k < WB; k++)
                    bram[(int'(base_addr) + k) % 256] = write_data[k*DW +: DW];
                wr_seen++;
                wr_cnt = int'($urandom_range(max_lat, 1));
            end
            if (done) done_cyc = cyc;

            // Adapter model drive for this cycle.
            flip_ready = 1'b0;
            wrt_done   = 1'b0;
            start      = 1'b0;
            read_data  = WW'($urandom);
            rd_fired   = 1'b0;
            if (rd_cnt == 0) begin
                flip_ready = 1'b1;
                read_data  = bram_word(rd_addr);
                rd_fired   = 1'b1;
                rd_cnt     = -1;
            end else if (rd_cnt > 0) begin
                rd_cnt--;
                wrt_done = pokes;
            end
            if (wr_cnt == 0) begin
                wrt_done   = 1'b1;
                flip_ready = pokes;
                wr_cnt     = -1;
            end else if (wr_cnt > 0) begin
                wr_cnt--;
                flip_ready = pokes;
            end
            if (pokes && cyc == 3) begin
                start = 1'b1; rect_base = 8'h00; rect_cols = 4'd1; rect_rows = 4'd1;
            end

            @(posedge clk); #1;
            cyc++;
        end

        check("done_seen", 32'(done_cyc >= 0), 1);
        check("rd_count", rd_seen, mute_rd ? 1 : exp_words);
        check("wr_count", wr_seen, mute_rd ? 0 : exp_words);
        check("words_done", 32'(words_done), mute_rd ? 0 : exp_words);
        check("err", 32'(err), 32'(mute_rd));
        check("busy_low", busy_low, 0);
        check("busy_end", 32'(busy), 0);
        if (mute_rd)
            check("to_lat", 32'((done_cyc - first_rd >= T) && (done_cyc - first_rd <= T + 2)), 1);
        if (exp_words == 0) begin
            check("empty_done_lat", done_cyc, 2);
            check("empty_busy", busy_high, 1);
        end

        flip_ready = 1'b0; wrt_done = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        check("done_pulse", 32'(done), 0);
        check("words_hold", 32'(words_done), mute_rd ? 0 : exp_words);
    endtask

    // Start a pass, stop acking once the write request is out, then reset
    // while the sequencer is waiting for wrt_done.
    task automatic reset_mid_pass();
        int cyc, events, rd_cnt;
        bit wr_seen;
        rect_base = 8'h40; rect_cols = 4'd3; rect_rows = 4'd1; row_pitch = 8'h00;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wr_seen = 1'b0; rd_cnt = -1; cyc = 0;
        while (!wr_seen && cyc < 200) begin
            flip_ready = 1'b0;
            if (st_read) rd_cnt = 2;
            if (st_write) wr_seen = 1'b1;
            if (rd_cnt == 0) begin
                flip_ready = 1'b1;
                read_data  = bram_word(base_addr);
                rd_cnt     = -1;
            end else if (rd_cnt > 0) begin
                rd_cnt--;
            end
            @(posedge clk); #1;
            cyc++;
        end
        flip_ready = 1'b0;
        check("rst_reach_wr", 32'(wr_seen), 1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #2;
        check_all_zero("rst_mid");
        @(posedge clk); #1;
        reset = 1'b0;
        events = 0;
        for (int i = 0; i < 10; i++) begin
            if (st_read || st_write || done || busy) events++;
            @(posedge clk); #1;
        end
        check("rst_quiet", events, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) bram[i] = 8'($urandom);
        reset = 1'b1; start = 1'b0;
        rect_base = '0; rect_cols = '0; rect_rows = '0; row_pitch = '0;
        read_data = '0; flip_ready = 1'b0; wrt_done = 1'b0;
        #2;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // 1x1 word at 0x10 holding 0x1234 is written back as 0x3412.
        bram[8'h10] = 8'h34; bram[8'h11] = 8'h12;
        run_pass(8'h10, 1, 1, 8'h00, 2, 1'b0, 1'b0);
        check("t1_wdata", 32'(write_data), 32'h3412);
        check("t1_lo", 32'(bram[8'h10]), 32'h12);
        check("t1_hi", 32'(bram[8'h11]), 32'h34);

        // 3x2 from 0x20 with pitch 0x10, with restart attempt and stray acks.
        run_pass(8'h20, 3, 2, 8'h10, 3, 1'b0, 1'b1);

        // Address wrap: 0xFE then 0x00.
        run_pass(8'hFE, 2, 1, 8'h00, 2, 1'b0, 1'b0);

        // Empty rectangles.
        run_pass(8'h30, 0, 5, 8'h08, 1, 1'b0, 1'b0);
        run_pass(8'h30, 3, 0, 8'h08, 1, 1'b0, 1'b0);

        // Adapter never answers the read: timeout, then a clean pass clears err.
        run_pass(8'h50, 2, 2, 8'h20, 1, 1'b1, 1'b0);
        run_pass(8'h60, 1, 2, 8'h04, 2, 1'b0, 1'b0);

        reset_mid_pass();
        run_pass(8'h70, 2, 1, 8'h00, 1, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            run_pass(8'($urandom), int'($urandom_range(4, 1)), int'($urandom_range(3, 1)),
                     8'($urandom), int'($urandom_range(4, 1)), 1'b0, 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
